// File: rtl/sram_sdp_port_ctrl.sv
// Access controller for a simple-dual-port SRAM with active-low enables and a
// one-cycle registered read. Two read requesters share the read port under
// round-robin arbitration. One write requester passes straight through to the
// write port. A same-cycle write to the address being read is forwarded to
// that read's response. A clear sweep zeroes every entry on command.
module sram_sdp_port_ctrl #(
    parameter int DATA_WIDTH = 88,
    parameter int ADDR_WIDTH = 10,
    parameter int RAM_DEPTH  = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear_start,
    output logic                  clear_busy,
    output logic                  clear_done,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd0_valid,
    output logic                  rd0_ready,
    input  logic [ADDR_WIDTH-1:0] rd0_addr,
    input  logic                  rd1_valid,
    output logic                  rd1_ready,
    input  logic [ADDR_WIDTH-1:0] rd1_addr,
    output logic                  rd0_rsp_valid,
    output logic                  rd1_rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  sram_wr_cen,
    output logic [ADDR_WIDTH-1:0] sram_wr_a,
    output logic [DATA_WIDTH-1:0] sram_wr_d,
    output logic                  sram_rd_cen,
    output logic [ADDR_WIDTH-1:0] sram_rd_a,
    input  logic [DATA_WIDTH-1:0] sram_rd_q
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(RAM_DEPTH - 1);

    typedef enum logic {
        NORMAL,
        CLEAR
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [ADDR_WIDTH-1:0]   count;
    logic [ADDR_WIDTH-1:0]   count_next;

    logic                    arb_en;
    logic                    grant0;
    logic                    grant1;
    logic                    wr_accept;
    logic                    collide;

    // rr_ptr low favours requester 0, high favours requester 1
    logic                    rr_ptr;
    logic                    rsp0_q;
    logic                    rsp1_q;
    logic                    bypass_q;
    logic [DATA_WIDTH-1:0]   bypass_data_q;

    // State and sweep counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= NORMAL;
            count <= '0;
        end else begin
            state <= state_next;
            count <= count_next;
        end
    end

    // Next state, sweep progress and write-port steering
    always_comb begin
        state_next  = state;
        count_next  = count;
        clear_busy  = 1'b0;
        clear_done  = 1'b0;
        wr_ready    = 1'b0;
        sram_wr_cen = 1'b1;
        sram_wr_a   = wr_addr;
        sram_wr_d   = wr_data;
        case (state)
            NORMAL: begin
                wr_ready    = ~clear_start;
                sram_wr_cen = ~(wr_valid & ~clear_start);
                if (clear_start) begin
                    state_next = CLEAR;
                    count_next = '0;
                end
            end
            CLEAR: begin
                clear_busy  = 1'b1;
                sram_wr_cen = 1'b0;
                sram_wr_a   = count;
                sram_wr_d   = '0;
                if (count == LAST_ADDR) begin
                    clear_done = 1'b1;
                    state_next = NORMAL;
                    count_next = '0;
                end else begin
                    count_next = count + 1'b1;
                end
            end
            default: begin
                state_next = NORMAL;
                count_next = '0;
            end
        endcase
    end

    // Round-robin read arbitration, blocked during a sweep and on its start cycle
    always_comb begin
        arb_en    = (state == NORMAL) & ~clear_start;
        grant0    = arb_en & rd0_valid & (~rd1_valid | ~rr_ptr);
        grant1    = arb_en & rd1_valid & ~grant0;
        rd0_ready = grant0;
        rd1_ready = grant1;
        sram_rd_cen = ~(grant0 | grant1);
        if (grant0) begin
            sram_rd_a = rd0_addr;
        end else if (grant1) begin
            sram_rd_a = rd1_addr;
        end else begin
            sram_rd_a = '0;
        end
        wr_accept = wr_valid & wr_ready;
        collide   = wr_accept & (grant0 | grant1) & (wr_addr == sram_rd_a);
    end

    // Arbitration pointer and response stage, including forwarded write data
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr        <= 1'b0;
            rsp0_q        <= 1'b0;
            rsp1_q        <= 1'b0;
            bypass_q      <= 1'b0;
            bypass_data_q <= '0;
        end else begin
            if (grant0) begin
                rr_ptr <= 1'b1;
            end else if (grant1) begin
                rr_ptr <= 1'b0;
            end
            rsp0_q   <= grant0;
            rsp1_q   <= grant1;
            bypass_q <= collide;
            if (collide) begin
                bypass_data_q <= wr_data;
            end
        end
    end

    // Response mux: forwarded data wins over the stale SRAM word, zero when idle
    always_comb begin
        rd0_rsp_valid = rsp0_q;
        rd1_rsp_valid = rsp1_q;
        if (rsp0_q | rsp1_q) begin
            rsp_data = bypass_q ? bypass_data_q : sram_rd_q;
        end else begin
            rsp_data = '0;
        end
    end

endmodule

// File: tb/tb_sram_sdp_port_ctrl.sv
// Self-checking bench for sram_sdp_port_ctrl: a directed vector table, hand
// sequences for clear and reset corners, then randomized traffic, all checked
// against a behavioural model where reads observe writes of the same cycle.
module tb_sram_sdp_port_ctrl;

    localparam int DW    = 88;
    localparam int AW    = 6;
    localparam int DEPTH = 40;
    localparam int MEMSZ = 1 << AW;

    logic          clk = 1'b0;
    logic          rst;
    logic          mem_init;
    logic          cs, wv, r0v, r1v;
    logic [AW-1:0] wa, r0a, r1a;
    logic [DW-1:0] wd;
    logic          clear_busy, clear_done, wr_ready, rd0_ready, rd1_ready;
    logic          rd0_rsp_valid, rd1_rsp_valid;
    logic [DW-1:0] rsp_data;
    logic          sram_wr_cen, sram_rd_cen;
    logic [AW-1:0] sram_wr_a, sram_rd_a;
    logic [DW-1:0] sram_wr_d, sram_rd_q;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic          cs;
        logic          wv;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
        logic          r0v;
        logic [AW-1:0] r0a;
        logic          r1v;
        logic [AW-1:0] r1a;
        logic          e_wrdy;
        logic          e_r0rdy;
        logic          e_r1rdy;
        logic          e_rsp0;
        logic          e_rsp1;
        logic [DW-1:0] e_data;
    } vec_t;

    vec_t tbl [11];

    // Behavioural model state
    logic [DW-1:0] refmem [MEMSZ];
    bit            m_clear;
    int            m_cnt;
    bit            m_ptr;
    bit            e_rsp0, e_rsp1;
    logic [DW-1:0] e_data;

    // Values sampled in the most recent cycle
    logic          last_busy, last_done, last_rsp0, last_rsp1, last_r0rdy;
    logic [DW-1:0] last_data;

    always #5 clk = ~clk;

    sram_sdp_port_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RAM_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .clear_start(cs), .clear_busy(clear_busy),
        .clear_done(clear_done), .wr_valid(wv), .wr_ready(wr_ready),
        .wr_addr(wa), .wr_data(wd), .rd0_valid(r0v), .rd0_ready(rd0_ready),
        .rd0_addr(r0a), .rd1_valid(r1v), .rd1_ready(rd1_ready), .rd1_addr(r1a),
        .rd0_rsp_valid(rd0_rsp_valid), .rd1_rsp_valid(rd1_rsp_valid),
        .rsp_data(rsp_data), .sram_wr_cen(sram_wr_cen), .sram_wr_a(sram_wr_a),
        .sram_wr_d(sram_wr_d), .sram_rd_cen(sram_rd_cen), .sram_rd_a(sram_rd_a),
        .sram_rd_q(sram_rd_q)
    );

    // SRAM instance model: registered read returns the pre-write word
    logic [DW-1:0] sram_mem [MEMSZ];
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < MEMSZ; i++) sram_mem[i] <= '0;
            sram_rd_q <= '0;
        end else begin
            if (!sram_wr_cen) sram_mem[sram_wr_a] <= sram_wr_d;
            if (!sram_rd_cen) sram_rd_q <= sram_mem[sram_rd_a];
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0b expected %0b", name, act, exp);
        end
    endtask

    task automatic chkv(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t stim(input logic c, input logic w, input int a,
                                  input logic [DW-1:0] d, input logic v0, input int a0,
                                  input logic v1, input int a1);
        vec_t v;
        v.cs = c;  v.wv = w;  v.wa = AW'(a);  v.wd = d;
        v.r0v = v0; v.r0a = AW'(a0); v.r1v = v1; v.r1a = AW'(a1);
        v.e_wrdy = 1'b0; v.e_r0rdy = 1'b0; v.e_r1rdy = 1'b0;
        v.e_rsp0 = 1'b0; v.e_rsp1 = 1'b0; v.e_data = '0;
        return v;
    endfunction

    function automatic vec_t mk(input vec_t s, input logic ew, input logic e0, input logic e1,
                                input logic er0, input logic er1, input logic [DW-1:0] ed);
        vec_t v = s;
        v.e_wrdy = ew; v.e_r0rdy = e0; v.e_r1rdy = e1;
        v.e_rsp0 = er0; v.e_rsp1 = er1; v.e_data = ed;
        return v;
    endfunction

    task automatic model_reset();
        m_clear = 0; m_cnt = 0; m_ptr = 0;
        e_rsp0 = 0; e_rsp1 = 0; e_data = '0;
    endtask

    task automatic set_idle();
        cs = 0; wv = 0; wa = '0; wd = '0; r0v = 0; r0a = '0; r1v = 0; r1a = '0;
    endtask

    // Drive one cycle from a negedge, check against the model (and the table
    // row when asked), advance the model across the posedge, end at negedge.
    task automatic apply_stimulus(input vec_t v, input bit use_table);
        bit            allow;
        int            win;
        logic [AW-1:0] waddr;
        bit            was_clear;
        cs = v.cs; wv = v.wv; wa = v.wa; wd = v.wd;
        r0v = v.r0v; r0a = v.r0a; r1v = v.r1v; r1a = v.r1a;
        #2;
        allow = !m_clear && !v.cs;
        if (!allow) win = -1;
        else if (v.r0v && v.r1v) win = m_ptr ? 1 : 0;
        else if (v.r0v) win = 0;
        else if (v.r1v) win = 1;
        else win = -1;
        check_output(allow, win);
        if (use_table) begin
            chk1("tbl_wr_ready", wr_ready, v.e_wrdy);
            chk1("tbl_rd0_ready", rd0_ready, v.e_r0rdy);
            chk1("tbl_rd1_ready", rd1_ready, v.e_r1rdy);
            chk1("tbl_rd0_rsp_valid", rd0_rsp_valid, v.e_rsp0);
            chk1("tbl_rd1_rsp_valid", rd1_rsp_valid, v.e_rsp1);
            chkv("tbl_rsp_data", 128'(rsp_data), 128'(v.e_data));
        end
        last_busy = clear_busy; last_done = clear_done; last_r0rdy = rd0_ready;
        last_rsp0 = rd0_rsp_valid; last_rsp1 = rd1_rsp_valid; last_data = rsp_data;
        @(posedge clk);
        was_clear = m_clear;
        if (was_clear) begin
            refmem[m_cnt] = '0;
            if (m_cnt == DEPTH - 1) begin m_clear = 0; m_cnt = 0; end
            else m_cnt++;
        end else if (v.wv && allow) begin
            refmem[v.wa] = v.wd;
        end
        e_rsp0 = (win == 0);
        e_rsp1 = (win == 1);
        if (win < 0) e_data = '0;
        else begin
            waddr  = (win == 0) ? v.r0a : v.r1a;
            e_data = refmem[waddr];
            m_ptr  = (win == 0);
        end
        if (!was_clear && v.cs) begin m_clear = 1; m_cnt = 0; end
        @(negedge clk);
    endtask

    task automatic check_output(input bit allow, input int win);
        bit exp_wcen;
        chk1("clear_busy", clear_busy, m_clear);
        chk1("clear_done", clear_done, m_clear && m_cnt == DEPTH - 1);
        chk1("wr_ready", wr_ready, allow);
        chk1("rd0_ready", rd0_ready, win == 0);
        chk1("rd1_ready", rd1_ready, win == 1);
        exp_wcen = m_clear ? 1'b0 : !(wv && allow);
        chk1("sram_wr_cen", sram_wr_cen, exp_wcen);
        if (m_clear) begin
            chkv("sram_wr_a_clear", 128'(sram_wr_a), 128'(m_cnt));
            chkv("sram_wr_d_clear", 128'(sram_wr_d), 128'(0));
        end else if (!exp_wcen) begin
            chkv("sram_wr_a", 128'(sram_wr_a), 128'(wa));
            chkv("sram_wr_d", 128'(sram_wr_d), 128'(wd));
        end
        chk1("sram_rd_cen", sram_rd_cen, win < 0);
        chkv("sram_rd_a", 128'(sram_rd_a),
             (win == 0) ? 128'(r0a) : (win == 1) ? 128'(r1a) : 128'(0));
        chk1("rd0_rsp_valid", rd0_rsp_valid, e_rsp0);
        chk1("rd1_rsp_valid", rd1_rsp_valid, e_rsp1);
        chkv("rsp_data", 128'(rsp_data), 128'(e_data));
    endtask

    // Asynchronous reset with idle inputs; outputs must drop without a clock edge
    task automatic reset_dut();
        set_idle();
        rst = 1;
        #2;
        chk1("rst_rd0_rsp_valid", rd0_rsp_valid, 1'b0);
        chk1("rst_rd1_rsp_valid", rd1_rsp_valid, 1'b0);
        chk1("rst_clear_busy", clear_busy, 1'b0);
        chk1("rst_clear_done", clear_done, 1'b0);
        chkv("rst_rsp_data", 128'(rsp_data), 128'(0));
        chk1("rst_sram_wr_cen", sram_wr_cen, 1'b1);
        chk1("rst_sram_rd_cen", sram_rd_cen, 1'b1);
        @(posedge clk);
        @(negedge clk);
        rst = 0;
        model_reset();
    endtask

    initial begin
        int busy_n;
        int done_at;
        vec_t v;

        // Directed vectors: {stimulus} followed by expected readies and response
        tbl[0]  = mk(stim(0,1,1,'h11,   0,0,0,0), 1,0,0, 0,0,'h0);
        tbl[1]  = mk(stim(0,1,2,'h22,   0,0,0,0), 1,0,0, 0,0,'h0);
        tbl[2]  = mk(stim(0,1,5,'hA5,   0,0,0,0), 1,0,0, 0,0,'h0);
        tbl[3]  = mk(stim(0,1,7,'h55,   1,5,0,0), 1,1,0, 0,0,'h0);
        tbl[4]  = mk(stim(0,0,0,'h0,    0,0,1,7), 1,0,1, 1,0,'hA5);
        tbl[5]  = mk(stim(0,0,0,'h0,    1,1,1,2), 1,1,0, 0,1,'h55);
        tbl[6]  = mk(stim(0,0,0,'h0,    1,1,1,2), 1,0,1, 1,0,'h11);
        tbl[7]  = mk(stim(0,0,0,'h0,    1,1,1,2), 1,1,0, 0,1,'h22);
        tbl[8]  = mk(stim(0,0,0,'h0,    1,1,1,2), 1,0,1, 1,0,'h11);
        tbl[9]  = mk(stim(0,1,7,'h1234, 0,0,1,7), 1,0,1, 0,1,'h22);
        tbl[10] = mk(stim(0,0,0,'h0,    0,0,0,0), 1,0,0, 0,1,'h1234);

        for (int i = 0; i < MEMSZ; i++) refmem[i] = '0;
        model_reset();
        set_idle();
        rst = 1;
        mem_init = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        mem_init = 0;
        chk1("reset_clear_busy", clear_busy, 1'b0);
        chk1("reset_clear_done", clear_done, 1'b0);
        chk1("reset_rd0_rsp_valid", rd0_rsp_valid, 1'b0);
        chk1("reset_rd1_rsp_valid", rd1_rsp_valid, 1'b0);
        chkv("reset_rsp_data", 128'(rsp_data), 128'(0));
        chk1("reset_sram_wr_cen", sram_wr_cen, 1'b1);
        chk1("reset_sram_rd_cen", sram_rd_cen, 1'b1);
        rst = 0;

        for (int i = 0; i < 11; i++) apply_stimulus(tbl[i], 1);

        // Preload both ends, grant rd0 just before clear_start, hold a write through the sweep
        apply_stimulus(stim(0,1,0,'hAAA,0,0,0,0), 0);
        apply_stimulus(stim(0,1,DEPTH-1,'hBBB,0,0,0,0), 0);
        apply_stimulus(stim(0,0,0,'h0,1,0,0,0), 0);
        apply_stimulus(stim(1,1,3,'h333,0,0,0,0), 0);
        chk1("pre_clear_rsp_valid", last_rsp0, 1'b1);
        chkv("pre_clear_rsp_data", 128'(last_data), 128'('hAAA));
        busy_n  = 0;
        done_at = -1;
        for (int k = 0; k < 3 * DEPTH; k++) begin
            apply_stimulus(stim(k == 10, 1, 3, 'h333, 0,0,0,0), 0);
            if (last_busy) busy_n++;
            if (last_done) done_at = k + 1;
            if (!last_busy) break;
        end
        chkv("clear_busy_cycles", 128'(busy_n), 128'(DEPTH));
        chkv("clear_done_cycle", 128'(done_at), 128'(DEPTH));
        apply_stimulus(stim(0,0,0,'h0,1,0,1,DEPTH-1), 0);
        apply_stimulus(stim(0,0,0,'h0,1,0,1,DEPTH-1), 0);
        chk1("readback_last_valid", last_rsp1, 1'b1);
        chkv("readback_last_data", 128'(last_data), 128'(0));
        apply_stimulus(stim(0,0,0,'h0,0,0,0,0), 0);
        chk1("readback_first_valid", last_rsp0, 1'b1);
        chkv("readback_first_data", 128'(last_data), 128'(0));

        // Reset mid-clear, then with a response pending and the pointer favouring rd1
        apply_stimulus(stim(1,0,0,'h0,0,0,0,0), 0);
        repeat (5) apply_stimulus(stim(0,0,0,'h0,0,0,0,0), 0);
        reset_dut();
        apply_stimulus(stim(0,0,0,'h0,1,5,0,0), 0);
        reset_dut();
        apply_stimulus(stim(0,0,0,'h0,1,1,1,2), 0);
        chk1("post_reset_rd0_first", last_r0rdy, 1'b1);
        apply_stimulus(stim(0,0,0,'h0,0,0,0,0), 0);

        // Randomized traffic with occasional clears and narrow address ranges for collisions
        for (int n = 0; n < 500; n++) begin
            int span;
            span = ($urandom_range(0, 1) == 0) ? 3 : DEPTH - 1;
            v = stim($urandom_range(0, 79) == 0, $urandom_range(0, 1) == 1,
                     $urandom_range(0, span), {$urandom, $urandom, $urandom},
                     $urandom_range(0, 2) != 0, $urandom_range(0, span),
                     $urandom_range(0, 2) != 0, $urandom_range(0, span));
            apply_stimulus(v, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
